io_mem_loader: RTL and testbench
================================

# io_mem_loader

Word-stream loader/dumper on the memory's IO port. Accepts a byte stream, assembles 16-bit words (high byte first) and writes them to consecutive memory addresses through the IO write port, or reads a range through the IO read port and streams it out as bytes. Programs and data are loaded into, and results dumped from, the unified 16-bit memory without touching the CPU ports.

## Interface
- MEM_SIZE, 200: number of valid memory words; a transfer range outside 0..MEM_SIZE-1 is rejected.
- CLK  in  1  system clock; all state changes on posedge.
- RSTN  in  1  reset, asynchronous, active-low.
- START  in  1  single-cycle request; sampled only in IDLE.
- MODE  in  1  0 = load (stream to memory), 1 = dump (memory to stream); sampled with START.
- BASE_ADDR  in  16  first word address; sampled with START.
- COUNT  in  16  number of words; sampled with START.
- RX_DATA  in  8  inbound byte.
- RX_VALID  in  1  inbound byte valid.
- RX_READY  out  1  loader accepts RX_DATA this cycle.
- TX_DATA  out  8  outbound byte.
- TX_VALID  out  1  outbound byte valid.
- TX_READY  in  1  sink accepts TX_DATA this cycle.
- WADDR_IO  out  16  memory IO write address.
- DATA_IN_IO  out  16  memory IO write data.
- MW_IO_ON  out  1  memory IO write enable.
- RADDR_IO  out  16  memory IO read address.
- DATA_OUT_IO  in  16  memory IO read data (combinational from RADDR_IO).
- BUSY  out  1  high from START acceptance until DONE.
- DONE  out  1  one-cycle pulse at end of transfer.
- ERR  out  1  one-cycle pulse with DONE when request rejected.

## Operation
- Reset: all outputs 0; state IDLE; address, word counter and byte holding register cleared. Reset mid-transfer aborts immediately; partial word discarded; MW_IO_ON drops asynchronously.
- States: IDLE, CHECK, LOAD_HI, LOAD_LO, WRITE, DUMP_RD, DUMP_HI, DUMP_LO, FIN.
- IDLE: START=1 latches MODE, BASE_ADDR, COUNT; -> CHECK; BUSY=1. START outside IDLE ignored.
- CHECK (1 cycle): if COUNT==0 -> FIN, ERR=0. If BASE_ADDR+COUNT (17-bit sum) > MEM_SIZE -> FIN with ERR=1, no memory access. Else -> LOAD_HI (MODE 0) or DUMP_RD (MODE 1).
- LOAD_HI: RX_READY=1; on RX_VALID&&RX_READY store byte as bits 15:8 -> LOAD_LO.
- LOAD_LO: RX_READY=1; on handshake form word {hi, RX_DATA}, register WADDR_IO=current address, DATA_IN_IO=word -> WRITE.
- WRITE (1 cycle): MW_IO_ON=1, RX_READY=0; address+1, remaining-1; -> LOAD_HI if remaining >0 else FIN.
- DUMP_RD (1 cycle): RADDR_IO=current address; capture DATA_OUT_IO into holding register at end of cycle -> DUMP_HI.
- DUMP_HI: TX_VALID=1, TX_DATA=bits 15:8, held stable until TX_READY -> DUMP_LO.
- DUMP_LO: TX_VALID=1, TX_DATA=bits 7:0 until TX_READY; then address+1, remaining-1; -> DUMP_RD or FIN.
- FIN (1 cycle): DONE=1 (ERR as set by CHECK), BUSY=0 next cycle, -> IDLE.
- MW_IO_ON is 0 in every state except WRITE. RX_READY is 0 outside LOAD_HI/LOAD_LO; TX_VALID 0 outside DUMP_HI/DUMP_LO.
- Address arithmetic 16-bit; range check guarantees no wrap past MEM_SIZE-1.

## Timing
- All outputs registered off posedge CLK, except MW_IO_ON async clear on reset.
- Memory writes at negedge; WADDR_IO/DATA_IN_IO/MW_IO_ON are stable a full half-cycle before the write edge and held for the whole WRITE cycle.
- Same-negedge CPU write to the same address: CPU data prevails; BUSY is provided so control can hold off CPU stores.
- START->first RX_READY: 2 cycles. Load throughput: 3 cycles/word with back-to-back RX_VALID. Dump: 3 cycles/word with TX_READY held high; first TX_VALID 3 cycles after START.
- DONE asserts the cycle after the last WRITE or last DUMP_LO handshake; CHECK->FIN->IDLE for rejected/zero requests: DONE 2 cycles after START.

## Test plan
- Load BASE=0x0010, COUNT=2, bytes 0xC0,0x11,0x12,0x34 with RX_VALID constant -> two MW_IO_ON pulses: addr 0x0010 data 0xC011, addr 0x0011 data 0x1234; DONE 1 cycle after second write; memory readback matches.
- Dump BASE=0x0000, COUNT=3 with TX_READY toggling every other cycle -> TX sequence matches memory[0..2] high-then-low bytes, TX_DATA never changes while TX_VALID&&!TX_READY.
- Range: BASE=199, COUNT=1 accepted; BASE=199, COUNT=2 -> DONE+ERR 2 cycles after START, MW_IO_ON never asserted; BASE=0xFFFF, COUNT=2 rejected (no wrap).
- COUNT=0 -> DONE=1, ERR=0 two cycles after START; no RX_READY, no TX_VALID.
- Reset asserted after high byte of word 2 in a load -> outputs 0 immediately, word 2 never written, next START begins cleanly from LOAD_HI.
- START pulses during BUSY and RX_VALID stalls of 5 cycles between bytes -> ignored START, correct words written, no extra MW_IO_ON.

Source files
------------

// File: rtl/io_mem_loader.sv
// io_mem_loader: byte-stream loader/dumper on the memory IO port.
// Words travel high byte first; every output comes straight off a flop.
module io_mem_loader #(
  parameter int MEM_SIZE = 200
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic        MODE,
  input  logic [15:0] BASE_ADDR,
  input  logic [15:0] COUNT,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic [15:0] WADDR_IO,
  output logic [15:0] DATA_IN_IO,
  output logic        MW_IO_ON,
  output logic [15:0] RADDR_IO,
  input  logic [15:0] DATA_OUT_IO,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam logic [16:0] Limit = 17'(MEM_SIZE);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD_HI,
    S_LOAD_LO,
    S_WRITE,
    S_DUMP_RD,
    S_DUMP_HI,
    S_DUMP_LO,
    S_FIN
  } state_e;

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] raddr_q, raddr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rx_rdy_q, rx_rdy_d;
  logic        tx_vld_q, tx_vld_d;
  logic        mw_q, mw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        rx_hs;
  logic        tx_hs;
  logic        last;
  logic [16:0] end_sum;
  logic [15:0] word;

  assign rx_hs   = RX_VALID & rx_rdy_q;
  assign tx_hs   = TX_READY & tx_vld_q;
  assign last    = (cnt_q == 16'd1);
  assign end_sum = {1'b0, addr_q} + {1'b0, cnt_q};
  assign word    = {hold_q[15:8], RX_DATA};

  // Next state, datapath updates and next values of registered outputs.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    raddr_d = raddr_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          mode_d  = MODE;
          addr_d  = BASE_ADDR;
          cnt_d   = COUNT;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cnt_q == 16'd0) begin
          state_d = S_FIN;
        end else if (end_sum > Limit) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else begin
          state_d = mode_q ? S_DUMP_RD : S_LOAD_HI;
        end
      end
      S_LOAD_HI: begin
        if (rx_hs) begin
          hold_d  = {RX_DATA, 8'h00};
          state_d = S_LOAD_LO;
        end
      end
      S_LOAD_LO: begin
        if (rx_hs) begin
          hold_d  = word;
          waddr_d = addr_q;
          wdata_d = word;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 16'd1;
        cnt_d   = cnt_q - 16'd1;
        state_d = last ? S_FIN : S_LOAD_HI;
      end
      S_DUMP_RD: begin
        hold_d  = DATA_OUT_IO;
        state_d = S_DUMP_HI;
      end
      S_DUMP_HI: begin
        if (tx_hs) state_d = S_DUMP_LO;
      end
      S_DUMP_LO: begin
        if (tx_hs) begin
          addr_d  = addr_q + 16'd1;
          cnt_d   = cnt_q - 16'd1;
          state_d = last ? S_FIN : S_DUMP_RD;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DUMP_RD) raddr_d = addr_d;

    rx_rdy_d = (state_d == S_LOAD_HI) || (state_d == S_LOAD_LO);
    tx_vld_d = (state_d == S_DUMP_HI) || (state_d == S_DUMP_LO);
    mw_d     = (state_d == S_WRITE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FIN);

    tx_data_d = 8'h00;
    unique case (1'b1)
      (state_d == S_DUMP_HI): tx_data_d = hold_d[15:8];
      (state_d == S_DUMP_LO): tx_data_d = hold_d[7:0];
      default: ;
    endcase
  end

  // State and output flops; reset aborts any transfer at once.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_q   <= '0;
      tx_data_q <= '0;
      rx_rdy_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      mw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      raddr_q   <= raddr_d;
      tx_data_q <= tx_data_d;
      rx_rdy_q  <= rx_rdy_d;
      tx_vld_q  <= tx_vld_d;
      mw_q      <= mw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign RX_READY   = rx_rdy_q;
  assign TX_DATA    = tx_data_q;
  assign TX_VALID   = tx_vld_q;
  assign WADDR_IO   = waddr_q;
  assign DATA_IN_IO = wdata_q;
  assign MW_IO_ON   = mw_q;
  assign RADDR_IO   = raddr_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_io_mem_loader.sv
// tb_io_mem_loader: randomized load/dump traffic against a word-level
// reference memory and transfer-timing model.
module tb_io_mem_loader;

  logic        CLK, RSTN, START, MODE;
  logic [15:0] BASE_ADDR, COUNT;
  logic [7:0]  RX_DATA;
  logic        RX_VALID, RX_READY;
  logic [7:0]  TX_DATA;
  logic        TX_VALID, TX_READY;
  logic [15:0] WADDR_IO, DATA_IN_IO;
  logic        MW_IO_ON;
  logic [15:0] RADDR_IO, DATA_OUT_IO;
  logic        BUSY, DONE, ERR;

  io_mem_loader #(.MEM_SIZE(200)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .MODE(MODE),
    .BASE_ADDR(BASE_ADDR), .COUNT(COUNT),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .WADDR_IO(WADDR_IO), .DATA_IN_IO(DATA_IN_IO), .MW_IO_ON(MW_IO_ON),
    .RADDR_IO(RADDR_IO), .DATA_OUT_IO(DATA_OUT_IO),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  assign DATA_OUT_IO = mem[RADDR_IO[7:0]];

  int n_cmp = 0;
  int n_bad = 0;

  int ncyc = 0;
  int start_cyc, done_cyc, last_mw;
  int done_cnt, done_err, mw_cnt;
  int first_rx, first_tx, rx_rdy_cnt, tx_v_cnt, tx_unstable;
  int tx_mode = 0;
  logic        tx_pend = 1'b0;
  logic [7:0]  tx_prev = 8'h00;
  logic [31:0] wr_log[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  byte_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Sink: 0 always ready, 1 toggling, 2 random.
  initial begin
    TX_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (tx_mode == 0) TX_READY = 1'b1;
      else if (tx_mode == 1) TX_READY = ~TX_READY;
      else TX_READY = 1'($urandom);
    end
  end

  // Memory array (writes at negedge) plus bus observation.
  always @(negedge CLK) begin
    ncyc++;
    if (MW_IO_ON) begin
      mem[WADDR_IO[7:0]] = DATA_IN_IO;
      wr_log.push_back({WADDR_IO, DATA_IN_IO});
      mw_cnt++;
      last_mw = ncyc;
    end
    if (DONE) begin
      done_cnt++;
      done_cyc = ncyc;
      done_err = int'(ERR);
    end
    if (RX_READY) begin
      rx_rdy_cnt++;
      if (first_rx < 0) first_rx = ncyc;
    end
    if (TX_VALID) begin
      tx_v_cnt++;
      if (first_tx < 0) first_tx = ncyc;
    end
    if (tx_pend && (!TX_VALID || TX_DATA != tx_prev)) tx_unstable++;
    tx_pend = TX_VALID && !TX_READY;
    tx_prev = TX_DATA;
    if (TX_VALID && TX_READY) tx_log.push_back(TX_DATA);
  end

  task automatic clear_stats();
    done_cnt = 0; done_err = 0; mw_cnt = 0;
    first_rx = -1; first_tx = -1;
    rx_rdy_cnt = 0; tx_v_cnt = 0; tx_unstable = 0;
    last_mw = -100; done_cyc = -100;
    wr_log.delete();
    tx_log.delete();
  endtask

  task automatic start_req(input bit m, input logic [15:0] b,
                           input logic [15:0] c);
    START = 1'b1; MODE = m; BASE_ADDR = b; COUNT = c;
    @(posedge CLK);
    #1;
    START = 1'b0;
    MODE = 1'($urandom);
    BASE_ADDR = 16'($urandom);
    COUNT = 16'($urandom);
    start_cyc = ncyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap,
                           input bit spam);
    logic hs;
    hs = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (spam) begin
        START = 1'b1; MODE = 1'($urandom);
        BASE_ADDR = 16'($urandom_range(0, 150));
        COUNT = 16'($urandom_range(1, 4));
      end
      @(posedge CLK);
      #1;
      START = 1'b0;
    end
    RX_DATA = b;
    RX_VALID = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge CLK);
      hs = RX_READY;
      @(posedge CLK);
      #1;
      if (hs) break;
    end
    if (!hs) chk("rx_timeout", 32'd0, 32'd1);
    RX_VALID = 1'b0;
    RX_DATA = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(posedge CLK);
      n++;
    end
    #1;
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic mem_cmp(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic run_xfer(input bit m, input logic [15:0] b,
                          input logic [15:0] c, input int gap,
                          input bit spam, input int txm,
                          input bit use_q);
    logic [16:0] sum;
    logic [15:0] w;
    bit valid, rej;
    int ec;
    sum = {1'b0, b} + {1'b0, c};
    valid = (c != 0) && (sum <= 17'd200);
    rej = (c != 0) && !valid;
    ec = valid ? int'(c) : 0;
    if (!use_q) begin
      byte_q.delete();
      if (!m) for (int i = 0; i < 2 * ec; i++) byte_q.push_back(8'($urandom));
    end
    tx_mode = txm;
    clear_stats();
    start_req(m, b, c);
    if (!m && valid)
      for (int i = 0; i < 2 * ec; i++) send_byte(byte_q[i], gap, spam);
    wait_done();
    chk("busy_after", 32'(BUSY), 32'd0);
    chk("done_n", 32'(done_cnt), 32'd1);
    chk("err", 32'(done_err), 32'(rej));
    if (!valid || (gap == 0 && txm == 0))
      chk("done_lat", 32'(done_cyc - start_cyc), 32'(2 + 3 * ec));
    chk("mw_n", 32'(mw_cnt), 32'(m ? 0 : ec));
    if (!m && valid) begin
      chk("rx_lat", 32'(first_rx - start_cyc), 32'd2);
      chk("done_after_wr", 32'(done_cyc - last_mw), 32'd1);
      for (int i = 0; i < ec; i++) begin
        w = {byte_q[2 * i], byte_q[2 * i + 1]};
        ref_mem[int'(b) + i] = w;
        if (i < wr_log.size())
          chk("wr", wr_log[i], {b + 16'(i), w});
      end
    end else begin
      chk("rx_idle", 32'(rx_rdy_cnt), 32'd0);
    end
    if (m && valid) begin
      chk("tx_lat", 32'(first_tx - start_cyc), 32'd3);
      chk("tx_n", 32'(tx_log.size()), 32'(2 * ec));
      for (int i = 0; i < tx_log.size() && i < 2 * ec; i++) begin
        w = ref_mem[int'(b) + i / 2];
        chk("tx", 32'(tx_log[i]), 32'((i % 2 == 0) ? w[15:8] : w[7:0]));
      end
      chk("tx_stable", 32'(tx_unstable), 32'd0);
    end else begin
      chk("tx_idle", 32'(tx_v_cnt), 32'd0);
    end
    mem_cmp("mem");
  endtask

  initial begin
    logic [15:0] b;
    logic [15:0] c;
    int r;
    RSTN = 1'b0; START = 1'b0; MODE = 1'b0;
    BASE_ADDR = '0; COUNT = '0; RX_DATA = '0; RX_VALID = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    clear_stats();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ctl", 32'({RX_READY, TX_VALID, MW_IO_ON, BUSY, DONE, ERR}), 32'd0);
    chk("rst_addr", {WADDR_IO, RADDR_IO}, 32'd0);
    chk("rst_data", 32'({DATA_IN_IO, TX_DATA}), 32'd0);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;

    byte_q = '{8'hC0, 8'h11, 8'h12, 8'h34};
    run_xfer(1'b0, 16'h0010, 16'd2, 0, 1'b0, 0, 1'b1);
    chk("mem10", 32'(mem[16]), 32'h0000C011);
    chk("mem11", 32'(mem[17]), 32'h00001234);
    run_xfer(1'b1, 16'h0010, 16'd2, 0, 1'b0, 0, 1'b0);

    run_xfer(1'b1, 16'h0000, 16'd3, 0, 1'b0, 1, 1'b0);
    run_xfer(1'b1, 16'd50, 16'd4, 0, 1'b0, 0, 1'b0);

    run_xfer(1'b0, 16'd199, 16'd1, 0, 1'b0, 0, 1'b0);
    run_xfer(1'b1, 16'd199, 16'd1, 0, 1'b0, 0, 1'b0);
    run_xfer(1'b0, 16'd199, 16'd2, 0, 1'b0, 0, 1'b0);
    run_xfer(1'b0, 16'hFFFF, 16'd2, 0, 1'b0, 0, 1'b0);
    run_xfer(1'b1, 16'hFFFF, 16'd2, 0, 1'b0, 0, 1'b0);
    run_xfer(1'b0, 16'd5, 16'd0, 0, 1'b0, 0, 1'b0);
    run_xfer(1'b1, 16'd5, 16'd0, 0, 1'b0, 0, 1'b0);

    // Reset after the high byte of word 2 of a 3-word load.
    tx_mode = 0;
    clear_stats();
    byte_q.delete();
    for (int i = 0; i < 3; i++) byte_q.push_back(8'($urandom));
    start_req(1'b0, 16'd40, 16'd3);
    for (int i = 0; i < 3; i++) send_byte(byte_q[i], 0, 1'b0);
    #1 RSTN = 1'b0;
    #1;
    chk("arst_ctl", 32'({RX_READY, TX_VALID, MW_IO_ON, BUSY, DONE, ERR}), 32'd0);
    chk("arst_wr", {WADDR_IO, DATA_IN_IO}, 32'd0);
    ref_mem[40] = {byte_q[0], byte_q[1]};
    repeat (2) @(posedge CLK);
    #3 RSTN = 1'b1;
    @(posedge CLK);
    #1;
    chk("arst_mw", 32'(mw_cnt), 32'd1);
    chk("arst_done", 32'(done_cnt), 32'd0);
    mem_cmp("arst_mem");
    run_xfer(1'b0, 16'd41, 16'd1, 0, 1'b0, 0, 1'b0);

    run_xfer(1'b0, 16'd100, 16'd3, 5, 1'b1, 0, 1'b0);
    chk("spam_quiet", 32'(BUSY), 32'd0);

    for (int it = 0; it < 25; it++) begin
      c = 16'($urandom_range(0, 6));
      r = $urandom_range(0, 9);
      if (r == 0) b = 16'($urandom);
      else if (r == 1) b = 16'd201 - c;
      else if (r == 2) b = 16'd200 - c;
      else b = 16'($urandom_range(0, 200 - int'(c)));
      run_xfer(1'($urandom), b, c, $urandom_range(0, 2),
               1'($urandom), $urandom_range(0, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
